// File: rtl/i2c_slave_responder_pkg.sv
// Shared types and constants for the I2C responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package i2c_slave_pkg;

  localparam int PTR_W = 4;

  // Bus level a receiver drives in the ACK slot
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_BYTE,
    WR_ACK,
    RD_BYTE,
    RD_ACK,
    IGNORE
  } state_e;

endpackage

// File: rtl/i2c_slave_responder_if.sv
// I2C bus wires as seen by the responder: sampled SCL/SDA plus open-drain pull-down.
// Latency: none, plain wires.
// Backpressure: none; the master owns SCL and the responder never stretches it.
interface i2c_slave_responder_if;
  logic scl_i;
  logic sda_i;
  logic sda_oe;

  modport slave  (input scl_i, sda_i, output sda_oe);
  modport master (output scl_i, sda_i, input sda_oe);
endinterface

// File: rtl/i2c_slave_responder_bus_sync.sv
// Synchronises SCL/SDA and derives SCL edge and START/STOP strobes.
// Latency: a bus edge shows up as a strobe after 2 sync flops + 1 edge register.
// Backpressure: none; strobes are single-cycle and must be consumed immediately.
module i2c_bus_sync (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);

  logic scl_meta_q, scl_sync_q, scl_last_q;
  logic sda_meta_q, sda_sync_q, sda_last_q;

  // Synchroniser chain plus one history stage; resets to the idle-bus level
  // so leaving reset on a quiet bus produces no spurious edges.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      scl_meta_q <= 1'b1;
      scl_sync_q <= 1'b1;
      scl_last_q <= 1'b1;
      sda_meta_q <= 1'b1;
      sda_sync_q <= 1'b1;
      sda_last_q <= 1'b1;
    end else begin
      scl_meta_q <= scl_i;
      scl_sync_q <= scl_meta_q;
      scl_last_q <= scl_sync_q;
      sda_meta_q <= sda_i;
      sda_sync_q <= sda_meta_q;
      sda_last_q <= sda_sync_q;
    end
  end

  assign scl_rise_o = scl_sync_q & ~scl_last_q;
  assign scl_fall_o = ~scl_sync_q & scl_last_q;
  // SDA may only move while SCL is steadily high for a START/STOP.
  assign start_o    = scl_sync_q & scl_last_q & sda_last_q & ~sda_sync_q;
  assign stop_o     = scl_sync_q & scl_last_q & ~sda_last_q & sda_sync_q;
  assign sda_o      = sda_sync_q;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C responder with a 16x8 register file addressed by an auto-incrementing pointer.
// Latency: bus edges act 3 clocks late; byte/start/stop pulses one cycle after detection.
// Backpressure: none; always ACKs writes and never stretches SCL.
module i2c_slave_responder
  import i2c_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         MEM_DEPTH  = 16
) (
  input  logic                 i2c_core_clock,
  input  logic                 preset,
  i2c_slave_responder_if.slave bus,
  output logic [7:0]           data_slave_read,
  output logic                 data_slave_read_valid,
  output logic                 start,
  output logic                 stop,
  output logic                 addr_match,
  input  logic [PTR_W-1:0]     mem_rd_addr,
  output logic [7:0]           mem_rd_data
);

  localparam logic [PTR_W-1:0] PTR_ONE = 1;

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .clk_i      (i2c_core_clock),
    .rst_n_i    (preset),
    .scl_i      (bus.scl_i),
    .sda_i      (bus.sda_i),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det),
    .sda_o      (sda_s)
  );

  state_e           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             first_q, first_d;   // next write byte is the pointer
  logic             rw_q, rw_d;
  logic             lead_q, lead_d;     // next SCL fall presents bit 7, no shift
  logic             oe_q, oe_d;
  logic             match_q, match_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             start_q, start_d;
  logic             stop_q, stop_d;
  logic [7:0]       mem_q [MEM_DEPTH];
  logic [7:0]       mem_d [MEM_DEPTH];

  logic [7:0] rx_byte;
  logic [7:0] cur_byte;
  assign rx_byte  = {shift_q[6:0], sda_s};
  assign cur_byte = mem_q[ptr_q];

  // State and datapath registers; reset aborts any transfer outright.
  always_ff @(posedge i2c_core_clock) begin
    if (!preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      ptr_q   <= '0;
      first_q <= 1'b0;
      rw_q    <= 1'b0;
      lead_q  <= 1'b0;
      oe_q    <= 1'b0;
      match_q <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      ptr_q   <= ptr_d;
      first_q <= first_d;
      rw_q    <= rw_d;
      lead_q  <= lead_d;
      oe_q    <= oe_d;
      match_q <= match_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      mem_q   <= mem_d;
    end
  end

  // Protocol FSM: STOP beats everything, START restarts addressing; otherwise
  // shift on SCL rise, and only ever move SDA after an SCL fall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    ptr_d   = ptr_q;
    first_d = first_q;
    rw_d    = rw_q;
    lead_d  = lead_q;
    oe_d    = oe_q;
    match_d = match_q;
    data_d  = data_q;
    valid_d = 1'b0;
    start_d = 1'b0;
    stop_d  = 1'b0;
    mem_d   = mem_q;

    if (stop_det) begin
      state_d = IDLE;
      oe_d    = 1'b0;
      match_d = 1'b0;
      stop_d  = 1'b1;
    end else if (start_det) begin
      state_d = ADDR;
      cnt_d   = '0;
      first_d = 1'b1;
      oe_d    = 1'b0;
      match_d = 1'b0;
      start_d = 1'b1;
    end else begin
      case (state_q)
        ADDR: if (scl_rise) begin
          shift_d = rx_byte;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (shift_q[6:0] == SLAVE_ADDR) begin
              state_d = ADDR_ACK;
              match_d = 1'b1;
              rw_d    = sda_s;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        // First fall pulls SDA for the ACK slot, second fall ends it.
        ADDR_ACK: if (scl_fall) begin
          if (!oe_q) begin
            oe_d = 1'b1;
          end else if (rw_q) begin
            shift_d = cur_byte;
            ptr_d   = ptr_q + PTR_ONE;
            oe_d    = ~cur_byte[7];
            cnt_d   = '0;
            lead_d  = 1'b0;
            state_d = RD_BYTE;
          end else begin
            oe_d    = 1'b0;
            cnt_d   = '0;
            state_d = WR_BYTE;
          end
        end
        WR_BYTE: if (scl_rise) begin
          shift_d = rx_byte;
          cnt_d   = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            valid_d = 1'b1;
            data_d  = rx_byte;
            if (first_q) begin
              ptr_d   = rx_byte[PTR_W-1:0];
              first_d = 1'b0;
            end else begin
              mem_d[ptr_q] = rx_byte;
              ptr_d        = ptr_q + PTR_ONE;
            end
            state_d = WR_ACK;
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!oe_q) begin
            oe_d = 1'b1;
          end else begin
            oe_d    = 1'b0;
            cnt_d   = '0;
            state_d = WR_BYTE;
          end
        end
        RD_BYTE: if (scl_fall) begin
          if (lead_q) begin
            oe_d   = ~shift_q[7];
            lead_d = 1'b0;
          end else if (cnt_q == 3'd7) begin
            oe_d    = 1'b0;
            state_d = RD_ACK;
          end else begin
            shift_d = {shift_q[6:0], 1'b0};
            oe_d    = ~shift_q[6];
            cnt_d   = cnt_q + 3'd1;
          end
        end
        RD_ACK: if (scl_rise) begin
          if (sda_s == ACK) begin
            shift_d = cur_byte;
            ptr_d   = ptr_q + PTR_ONE;
            cnt_d   = '0;
            lead_d  = 1'b1;
            state_d = RD_BYTE;
          end else begin
            state_d = IGNORE;
          end
        end
        IGNORE:  oe_d = 1'b0;
        IDLE:    oe_d = 1'b0;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.sda_oe            = oe_q;
  assign data_slave_read       = data_q;
  assign data_slave_read_valid = valid_q;
  assign start                 = start_q;
  assign stop                  = stop_q;
  assign addr_match            = match_q;
  assign mem_rd_data           = mem_q[mem_rd_addr];

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: bit-banged I2C master, scoreboard on received-byte pulses.
// Latency: SCL quarter period of 8 core clocks.
// Backpressure: n/a.
module tb_i2c_slave_responder;

  localparam int Q = 80;

  logic       clk = 1'b0;
  logic       preset = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic [7:0] data_slave_read;
  logic       data_slave_read_valid;
  logic       start, stop, addr_match;
  logic [3:0] mem_rd_addr = '0;
  logic [7:0] mem_rd_data;

  i2c_slave_responder_if bus();
  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;

  i2c_slave_responder dut (
    .i2c_core_clock        (clk),
    .preset                (preset),
    .bus                   (bus),
    .data_slave_read       (data_slave_read),
    .data_slave_read_valid (data_slave_read_valid),
    .start                 (start),
    .stop                  (stop),
    .addr_match            (addr_match),
    .mem_rd_addr           (mem_rd_addr),
    .mem_rd_data           (mem_rd_data)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q [$];
  int         start_cnt = 0;
  int         stop_cnt = 0;
  int         oe_hi_cnt = 0;
  int         oe_viol = 0;
  logic       oe_prev = 1'b0;
  logic       scl_prev = 1'b1;

  // Scoreboard monitor: every byte pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (data_slave_read_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL rx_byte: got unexpected %02h, required no pulse", data_slave_read);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_slave_read !== e) begin
          n_errors++;
          $display("FAIL rx_byte: got %02h required %02h", data_slave_read, e);
        end
      end
    end
    if (start === 1'b1) start_cnt++;
    if (stop === 1'b1) stop_cnt++;
    if (bus.sda_oe === 1'b1) oe_hi_cnt++;
    if (bus.sda_oe !== oe_prev && scl_m && scl_prev) oe_viol++;
    oe_prev  = bus.sda_oe;
    scl_prev = scl_m;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  task automatic check_mem(input string name, input logic [3:0] a, input logic [7:0] exp);
    mem_rd_addr = a;
    #1;
    check(name, {24'h0, mem_rd_data}, {24'h0, exp});
  endtask

  task automatic clk_bit(input logic b, output logic s);
    sda_m = b;
    #Q; scl_m = 1'b1;
    #Q; s = bus.sda_i;
    #Q; scl_m = 1'b0;
    #Q;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    #Q; scl_m = 1'b1;
    #Q; sda_m = 1'b0;
    #Q; scl_m = 1'b0;
    #Q;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    #Q; scl_m = 1'b1;
    #Q; sda_m = 1'b1;
    #(2*Q);
  endtask

  task automatic wbyte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], s);
    clk_bit(1'b1, ack);
  endtask

  task automatic rbyte(input logic nack, output logic [7:0] d);
    logic s;
    d = '0;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, s);
      d = {d[6:0], s};
    end
    clk_bit(nack, s);
  endtask

  // Basic write: pointer 3, then A5, 3C.
  task automatic scen1();
    logic a;
    int   s0, t0;
    s0 = start_cnt;
    t0 = stop_cnt;
    i2c_start();
    wbyte(8'hA0, a);        check("s1_addr_ack", a, 0);
    check("s1_addr_match", addr_match, 1);
    exp_q.push_back(8'h03);
    wbyte(8'h03, a);        check("s1_ptr_ack", a, 0);
    exp_q.push_back(8'hA5);
    wbyte(8'hA5, a);        check("s1_d0_ack", a, 0);
    exp_q.push_back(8'h3C);
    wbyte(8'h3C, a);        check("s1_d1_ack", a, 0);
    i2c_stop();
    check("s1_match_after_stop", addr_match, 0);
    check("s1_start_pulses", start_cnt - s0, 1);
    check("s1_stop_pulses", stop_cnt - t0, 1);
    check_mem("s1_mem3", 4'd3, 8'hA5);
    check_mem("s1_mem4", 4'd4, 8'h3C);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic       a;
    logic [7:0] d;
    int         s0;

    // Reset state
    repeat (5) @(posedge clk);
    #1;
    check("rst_sda_oe", bus.sda_oe, 0);
    check("rst_valid", data_slave_read_valid, 0);
    check("rst_data", data_slave_read, 0);
    check("rst_start_stop", {start, stop}, 0);
    check("rst_match", addr_match, 0);
    check_mem("rst_mem0", 4'd0, 8'h00);
    preset = 1'b1;
    repeat (10) @(posedge clk);

    // 1: plain write
    scen1();

    // 2: pointer write, repeated START, read A5 (ACK), 3C (NACK)
    i2c_start();
    wbyte(8'hA0, a);
    exp_q.push_back(8'h03);
    wbyte(8'h03, a);
    s0 = start_cnt;
    i2c_start();
    check("s2_rstart_pulse", start_cnt - s0, 1);
    wbyte(8'hA1, a);        check("s2_raddr_ack", a, 0);
    rbyte(1'b0, d);         check("s2_rd0", d, 8'hA5);
    rbyte(1'b1, d);         check("s2_rd1", d, 8'h3C);
    i2c_stop();
    // pointer should now sit at 5: a fresh read returns mem[5]
    check_mem("s2_mem5_zero", 4'd5, 8'h00);
    i2c_start();
    wbyte(8'hA1, a);
    rbyte(1'b1, d);         check("s2_ptr5_read", d, 8'h00);
    i2c_stop();

    // 3: foreign address is ignored
    oe_hi_cnt = 0;
    i2c_start();
    wbyte(8'hA2, a);        check("s3_addr_nack", a, 1);
    check("s3_no_match", addr_match, 0);
    wbyte(8'h55, a);        check("s3_d0_nack", a, 1);
    wbyte(8'h66, a);
    i2c_stop();
    check("s3_oe_never", oe_hi_cnt, 0);
    check_mem("s3_mem3_kept", 4'd3, 8'hA5);

    // 4: pointer wrap on write and read
    i2c_start();
    wbyte(8'hA0, a);
    exp_q.push_back(8'h0F); wbyte(8'h0F, a);
    exp_q.push_back(8'h11); wbyte(8'h11, a);
    exp_q.push_back(8'h22); wbyte(8'h22, a);
    i2c_stop();
    check_mem("s4_mem15", 4'd15, 8'h11);
    check_mem("s4_mem0", 4'd0, 8'h22);
    i2c_start();
    wbyte(8'hA0, a);
    exp_q.push_back(8'hFF); wbyte(8'hFF, a);   // high nibble ignored -> ptr 0xF
    i2c_start();
    wbyte(8'hA1, a);
    rbyte(1'b0, d);         check("s4_rd15", d, 8'h11);
    rbyte(1'b1, d);         check("s4_rd0", d, 8'h22);
    i2c_stop();

    // 5: STOP inside a data byte discards it
    i2c_start();
    wbyte(8'hA0, a);
    exp_q.push_back(8'h07); wbyte(8'h07, a);
    for (int i = 0; i < 4; i++) clk_bit(1'b1, a);
    i2c_stop();
    check_mem("s5_mem7_untouched", 4'd7, 8'h00);
    check("s5_match_cleared", addr_match, 0);
    scen1();

    // 6: reset while driving a read bit low
    i2c_start();
    wbyte(8'hA0, a);
    exp_q.push_back(8'h04); wbyte(8'h04, a);
    i2c_start();
    wbyte(8'hA1, a);        check("s6_raddr_ack", a, 0);
    sda_m = 1'b1;
    #Q;
    check("s6_oe_driving", bus.sda_oe, 1);
    preset = 1'b0;
    @(posedge clk);
    #1;
    check("s6_oe_reset", bus.sda_oe, 0);
    check("s6_match_reset", addr_match, 0);
    for (int i = 0; i < 16; i++) check_mem("s6_mem_clear", i[3:0], 8'h00);
    scl_m = 1'b1;
    sda_m = 1'b1;
    repeat (10) @(posedge clk);
    preset = 1'b1;
    repeat (10) @(posedge clk);
    scen1();

    repeat (20) @(posedge clk);
    check("pending_expected_bytes", exp_q.size(), 0);
    check("oe_stable_scl_high", oe_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_slave_responder.md
# i2c_slave_responder

- Synthesizable I2C slave (responder) for the other end of the APB I2C master's bus.
- Oversamples SCL/SDA on the I2C core clock, detects START/STOP, and matches a 7-bit address.
- Writes and reads a 16×8 register file through an auto-incrementing pointer.
- Reports every byte it receives, so the bench scoreboard can compare it against the master's transmit data.

## Interface
Parameters:
- SLAVE_ADDR, 7'h50, 7-bit address this responder answers to
- MEM_DEPTH, 16, register file entries (pointer width = 4)

Ports:
- i2c_core_clock  in  1  sole clock; ≥ 8× SCL frequency
- preset  in  1  reset, synchronous, active-low
- scl_i  in  1  SCL bus level (asynchronous)
- sda_i  in  1  SDA bus level (asynchronous)
- sda_oe  out  1  1 = pull SDA low (open-drain); tied to sda_io by bench/top
- data_slave_read  out  8  last byte received from master
- data_slave_read_valid  out  1  one-cycle pulse, data_slave_read valid
- start  out  1  one-cycle pulse on START or repeated START
- stop  out  1  one-cycle pulse on STOP
- addr_match  out  1  high from address ACK until next START/STOP
- mem_rd_addr  in  4  bench inspection index
- mem_rd_data  out  8  mem[mem_rd_addr], combinational

## Operation
Reset (preset=0 on a clock edge):
- All outputs 0, including sda_oe (SDA released).
- mem all 8'h00, pointer 0, state IDLE.
- Reset mid-transfer aborts immediately; no partial effects survive.

Bus front end:
- 2-flop synchronizers, then one registered copy for edge detection.
- START = SDA fall while SCL high. STOP = SDA rise while SCL high. Both are valid in any state.
- START → ADDR from any state, including a repeated START; the pointer is retained.
- STOP → IDLE from any state; any partial byte is discarded with no valid pulse.

States:
- IDLE: waits for START.
- ADDR: shifts 8 bits MSB-first on SCL rise.
  - Bits[7:1]==SLAVE_ADDR → ADDR_ACK and set addr_match.
  - Otherwise → IGNORE.
- ADDR_ACK: drives ACK for one SCL period.
  - R/W bit 0 → WR_BYTE.
  - R/W bit 1 → RD_BYTE, loading shift register with mem[ptr] and ptr←ptr+1.
- WR_BYTE: 8 bits shifted on SCL rise.
  - Byte pulses data_slave_read_valid with data_slave_read = byte.
  - First byte after the address is the pointer (ptr←byte[3:0]); it is not stored in mem.
  - Later bytes: mem[ptr]←byte, ptr←ptr+1.
  - → WR_ACK.
- WR_ACK: slave ACKs every write byte, then → WR_BYTE.
- RD_BYTE: drives sda_oe = ~bit (MSB first), advancing on each SCL fall; after bit 0 → RD_ACK.
- RD_ACK: SDA released; master bit sampled on SCL rise.
  - 0 (ACK) → load mem[ptr], ptr+1, → RD_BYTE.
  - 1 (NACK) → IGNORE.
- IGNORE: sda_oe=0; waits for START/STOP.

Arithmetic:
- Pointer is 4-bit modulo; 15+1 wraps to 0 for both read and write.
- High 4 bits of the pointer byte are ignored.

## Timing
- Input latency: a bus edge is recognised 3 clocks after it occurs (2 sync + 1 edge register).
- sda_oe changes only on the clock after a detected SCL fall. It never changes while SCL is high, so there are no false START/STOP.
- ACK: sda_oe=1 from the SCL fall after bit 0 until the next SCL fall.
- data_slave_read_valid: asserted the cycle after the 8th SCL rise is detected; pulses exactly once per byte.
- start/stop: asserted the cycle after detection.
- mem write: occurs in the same cycle as data_slave_read_valid.
- Simultaneous START detection and an SCL edge cannot occur, since SCL is high. If STOP and a byte completion collide, STOP wins.

## Structure
- Package i2c_slave_pkg:
  - state enum (IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE)
  - PTR_W=4
  - ACK=1'b0, NACK=1'b1
- Sub-module i2c_bus_sync: synchronizers, scl_rise/scl_fall strobes, start/stop strobes, sda sample.
- Top module holds the FSM, bit counter (0..7), shift register, pointer and mem.

## Test plan
1. START, 0xA0 (0x50 W), pointer 0x03, data 0xA5, 0x3C, STOP → four ACKs; valid pulses 0x03, 0xA5, 0x3C; mem[3]=0xA5, mem[4]=0x3C; one start and one stop pulse.
2. Write pointer 0x03, repeated START, 0xA1, read with ACK then NACK → SDA carries 0xA5 then 0x3C; second start pulse; pointer=5.
3. START, 0xA2 (address 0x51) plus 2 bytes → sda_oe never 1; addr_match 0; no valid pulses.
4. Pointer 0x0F, write 0x11, 0x22 → mem[15]=0x11, mem[0]=0x22; read from pointer 0x0F returns 0x11, 0x22.
5. STOP after 4 bits of a data byte → no valid pulse, mem unchanged, IDLE; the next full transaction behaves as in scenario 1.
6. preset=0 mid-RD_BYTE with sda_oe=1 → sda_oe=0 on that edge, all mem reads 0x00; release reset, then scenario 1 passes.
